// File: rtl/control_circuit.sv
// control_circuit: fetch/decode sequencer for the 8-register single-bus datapath.
// Latency: LOAD 3, MOV 2, ADD/SUB 4, NOP 2 cycles including fetch; outputs decode state+IR.
// No backpressure: T0 always follows the done cycle. Optional SUB via macro CC_SUB_EN.
module control_circuit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    output logic        ext_data_en,
    output logic        ext_data_low_reg_en,
    output logic [7:0]  reg_in_en,
    output logic [7:0]  reg_out_en,
    output logic        alu_reg_en,
    output logic        alu_sel,
    output logic        alu_out_en,
    output logic        g_reg_en,
    output logic        done
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [3:0] OP_LOAD = 4'b0000;
    localparam logic [3:0] OP_MOV  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;

    state_t      state;
    logic [15:0] ir;
    logic [3:0]  opcode;
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic        is_arith;
    logic [7:0]  rx_hot;
    logic [7:0]  ry_hot;

    assign opcode = ir[15:12];
    assign rx     = ir[10:8];
    assign ry     = ir[6:4];
    assign rx_hot = 8'd1 << rx;
    assign ry_hot = 8'd1 << ry;

`ifdef CC_SUB_EN
    assign is_arith = (opcode == OP_ADD) || (opcode == OP_SUB);
`else
    // Without subtract support, opcode 0011 falls through to the NOP path.
    assign is_arith = (opcode == OP_ADD);
`endif

    // The immediate travels to the datapath through its own register, and
    // IR[11]/IR[3] are don't-care fields, so these bits are not decoded here.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{ir[11], ir[7], ir[3:0]};

    // State register and instruction register; IR only captures in fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= T0;
            ir    <= 16'h0000;
        end else begin
            case (state)
                T0: begin
                    ir    <= instr;
                    state <= T1;
                end
                T1: begin
                    if (opcode == OP_LOAD || is_arith)
                        state <= T2;
                    else
                        state <= T0;
                end
                T2: begin
                    if (is_arith)
                        state <= T3;
                    else
                        state <= T0;
                end
                default: state <= T0;
            endcase
        end
    end

    // Control decode from registered state and IR; no path from instr.
    always_comb begin
        ext_data_en         = 1'b0;
        ext_data_low_reg_en = 1'b0;
        reg_in_en           = 8'h00;
        reg_out_en          = 8'h00;
        alu_reg_en          = 1'b0;
        alu_sel             = 1'b0;
        alu_out_en          = 1'b0;
        g_reg_en            = 1'b0;
        done                = 1'b0;
        case (state)
            T1: begin
                if (opcode == OP_LOAD) begin
                    ext_data_low_reg_en = 1'b1;
                end else if (opcode == OP_MOV) begin
                    reg_out_en = ry_hot;
                    reg_in_en  = rx_hot;
                    done       = 1'b1;
                end else if (is_arith) begin
                    reg_out_en = rx_hot;
                    alu_reg_en = 1'b1;
                end else begin
                    done = 1'b1;
                end
            end
            T2: begin
                if (opcode == OP_LOAD) begin
                    ext_data_en = 1'b1;
                    reg_in_en   = rx_hot;
                    done        = 1'b1;
                end else if (is_arith) begin
                    reg_out_en = ry_hot;
                    g_reg_en   = 1'b1;
`ifdef CC_SUB_EN
                    alu_sel    = opcode[0];
`endif
                end
            end
            T3: begin
                alu_out_en = 1'b1;
                reg_in_en  = rx_hot;
                done       = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_circuit.sv
// Directed bench for control_circuit: expected output vectors are queued per step
// and compared at each sample point, 1 time unit after the rising edge.
module tb_control_circuit;

    logic        clk;
    logic        rst;
    logic [15:0] instr;
    logic        ext_data_en;
    logic        ext_data_low_reg_en;
    logic [7:0]  reg_in_en;
    logic [7:0]  reg_out_en;
    logic        alu_reg_en;
    logic        alu_sel;
    logic        alu_out_en;
    logic        g_reg_en;
    logic        done;

    typedef struct packed {
        logic       ext;
        logic       ext_low;
        logic [7:0] rin;
        logic [7:0] rout;
        logic       areg;
        logic       sel;
        logic       aout;
        logic       g;
        logic       done;
    } out_t;

    out_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    control_circuit dut (
        .clk                 (clk),
        .rst                 (rst),
        .instr               (instr),
        .ext_data_en         (ext_data_en),
        .ext_data_low_reg_en (ext_data_low_reg_en),
        .reg_in_en           (reg_in_en),
        .reg_out_en          (reg_out_en),
        .alu_reg_en          (alu_reg_en),
        .alu_sel             (alu_sel),
        .alu_out_en          (alu_out_en),
        .g_reg_en            (g_reg_en),
        .done                (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk(input logic ext, input logic ext_low,
                                input logic [7:0] rin, input logic [7:0] rout,
                                input logic areg, input logic sel, input logic aout,
                                input logic g, input logic dn);
        out_t v;
        v = '{ext, ext_low, rin, rout, areg, sel, aout, g, dn};
        return v;
    endfunction

    task automatic expect_out(input out_t v);
        sb.push_back(v);
    endtask

    task automatic check(input string tag);
        out_t obs;
        out_t exp;
        obs = {ext_data_en, ext_data_low_reg_en, reg_in_en, reg_out_en,
               alu_reg_en, alu_sel, alu_out_en, g_reg_en, done};
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
        end else begin
            exp = sb.pop_front();
            assert (obs === exp) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    out_t zero;

    initial begin
        zero  = '0;
        rst   = 1'b1;
        instr = 16'h0101;
        #2;
        expect_out(zero); check("reset_outputs");
        @(negedge clk);
        rst = 1'b0;

        // LOAD R1: fetch, T1, T2
        expect_out(zero); check("load_t0");
        tick(); expect_out(mk(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0)); check("load_t1");
        tick(); expect_out(mk(1, 0, 8'h02, 8'h00, 0, 0, 0, 0, 1)); check("load_t2");
        tick();

        // LOAD R2 with instr scrambled after fetch
        instr = 16'h0201;
        expect_out(zero); check("load2_t0");
        tick(); instr = 16'h0000;
        expect_out(mk(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 0)); check("load2_t1");
        tick(); expect_out(mk(1, 0, 8'h04, 8'h00, 0, 0, 0, 0, 1)); check("load2_t2");
        tick();

        // MOV R5 <- R3
        instr = 16'h1530;
        expect_out(zero); check("mov_t0");
        tick(); expect_out(mk(0, 0, 8'h20, 8'h08, 0, 0, 0, 0, 1)); check("mov_t1");
        tick();

        // MOV R6 <- R6
        instr = 16'h1660;
        expect_out(zero); check("mov_same_t0");
        tick(); expect_out(mk(0, 0, 8'h40, 8'h40, 0, 0, 0, 0, 1)); check("mov_same_t1");
        tick();

        // SUB R1 <- R1 - R2
        instr = 16'h3120;
        expect_out(zero); check("sub_t0");
`ifdef CC_SUB_EN
        tick(); expect_out(mk(0, 0, 8'h00, 8'h02, 1, 0, 0, 0, 0)); check("sub_t1");
        tick(); expect_out(mk(0, 0, 8'h00, 8'h04, 0, 1, 0, 1, 0)); check("sub_t2");
        tick(); expect_out(mk(0, 0, 8'h02, 8'h00, 0, 0, 1, 0, 1)); check("sub_t3");
`else
        tick(); expect_out(mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1)); check("sub_as_nop_t1");
`endif
        tick();

        // ADD R3 <- R3 + R7
        instr = 16'h2371;
        expect_out(zero); check("add_t0");
        tick(); expect_out(mk(0, 0, 8'h00, 8'h08, 1, 0, 0, 0, 0)); check("add_t1");
        tick(); expect_out(mk(0, 0, 8'h00, 8'h80, 0, 0, 0, 1, 0)); check("add_t2");
        tick(); expect_out(mk(0, 0, 8'h08, 8'h00, 0, 0, 1, 0, 1)); check("add_t3");
        tick();

        // Unknown opcode 0xF
        instr = 16'hF000;
        expect_out(zero); check("nop_t0");
        tick(); expect_out(mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1)); check("nop_t1");
        tick();
        expect_out(zero); check("nop_back_to_t0");

        // Reset during T2 of ADD R4 <- R4 + R5
        instr = 16'h2450;
        tick(); expect_out(mk(0, 0, 8'h00, 8'h10, 1, 0, 0, 0, 0)); check("abort_t1");
        tick(); expect_out(mk(0, 0, 8'h00, 8'h20, 0, 0, 0, 1, 0)); check("abort_t2");
        rst = 1'b1;
        #1;
        expect_out(zero); check("abort_immediate");
        instr = 16'h1230;
        tick(); expect_out(zero); check("abort_held");
        @(negedge clk);
        rst = 1'b0;
        #1;
        expect_out(zero); check("post_reset_t0");
        tick(); expect_out(mk(0, 0, 8'h04, 8'h08, 0, 0, 0, 0, 1)); check("post_reset_mov_t1");
        tick(); expect_out(zero); check("post_reset_t0_again");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_circuit.md
# control_circuit

Sequencing control unit for the 8-register, single-bus datapath. It fetches a 16-bit instruction into an internal instruction register and steps a small state machine through the instruction. Each step drives the one-hot bus-source, register-load and ALU enables that the datapath (register file, external-data path, A/G registers, ALU) consumes. It pulses `done` on the final step of every instruction, then returns to fetch.

## Interface
Parameters: none.
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `instr`  in  16  instruction word; sampled only in fetch state T0
- `ext_data_en`  out  1  drive external-data low register (zero-extended) onto bus
- `ext_data_low_reg_en`  out  1  load IR[7:0] into external-data low register
- `reg_in_en`  out  8  one-hot load enable for R0..R7 from bus
- `reg_out_en`  out  8  one-hot bus-drive enable for R0..R7
- `alu_reg_en`  out  1  load ALU A register from bus
- `alu_sel`  out  1  ALU function: 0 add, 1 subtract
- `alu_out_en`  out  1  drive G register onto bus
- `g_reg_en`  out  1  load G register from ALU result
- `done`  out  1  high during the last step of an instruction

## Operation
- Instruction fields:
  - IR[15:12] opcode
  - IR[10:8] Rx (destination / first operand)
  - IR[6:4] Ry (source)
  - IR[7:0] immediate for LOAD
  - IR[11] and IR[3] ignored
- States: T0 (fetch), T1, T2, T3.
- T0: IR <= `instr`; all outputs 0; next state T1.
- LOAD (0000):
  - T1: `ext_data_low_reg_en`=1.
  - T2: `ext_data_en`=1, `reg_in_en`[Rx]=1, `done`=1; next state T0.
- MOV (0001):
  - T1: `reg_out_en`[Ry]=1, `reg_in_en`[Rx]=1, `done`=1; next state T0.
- ADD (0010) / SUB (0011):
  - T1: `reg_out_en`[Rx]=1, `alu_reg_en`=1.
  - T2: `reg_out_en`[Ry]=1, `g_reg_en`=1, `alu_sel`=opcode[0].
  - T3: `alu_out_en`=1, `reg_in_en`[Rx]=1, `done`=1; next state T0.
- Any other opcode is a NOP: T1 asserts only `done`=1; next state T0.
- At most one bus driver per cycle: at most one of `ext_data_en`, `alu_out_en`, or a single `reg_out_en` bit.
- `alu_sel` is 0 in every state except T2 of SUB.
- Changes on `instr` outside T0 have no effect.
- MOV with Rx==Ry asserts the same bit in both `reg_out_en` and `reg_in_en`. This is legal.

## Timing
- Outputs are pure combinational decode of the registered state and IR. They change only after a rising `clk` edge or on `rst`. There is no path from `instr` to any output.
- Reset:
  - state=T0, IR=0.
  - Every output is 0 while `rst` is high and immediately on assertion.
  - Reset mid-instruction aborts it with no `done`.
  - The first rising edge after `rst` falls performs a fetch.
- Instruction latency, including the fetch cycle:
  - LOAD: 3 cycles
  - MOV: 2 cycles
  - ADD/SUB: 4 cycles
  - NOP: 2 cycles
- `done` is high for exactly one cycle per instruction, in the cycle before the next T0.
- Back-to-back operation: T0 always follows the `done` cycle, with no stall input.

## Configuration
- `CC_SUB_EN` defined: opcode 0011 executes SUB as specified above.
- `CC_SUB_EN` not defined:
  - Opcode 0011 decodes as a NOP (T1 `done` only).
  - `alu_sel` is tied to 0.
  - ADD is unaffected.

## Test plan
- Reset, then `instr`=0x0101 held: cycle 1 all 0; cycle 2 `ext_data_low_reg_en`=1; cycle 3 `ext_data_en`=1, `reg_in_en`=0x02, `done`=1; cycle 4 fetch.
- `instr`=0x0201 applied to T0 while `instr` toggles to 0x0000 afterwards: the LOAD still targets R2 (`reg_in_en`=0x04 in T2). This shows the IR isolates `instr`.
- MOV `instr`=0x1530: T1 `reg_out_en`=0x08, `reg_in_en`=0x20, `done`=1.
- SUB `instr`=0x3120 with `CC_SUB_EN` defined:
  - T1 `reg_out_en`=0x02, `alu_reg_en`=1.
  - T2 `reg_out_en`=0x04, `g_reg_en`=1, `alu_sel`=1.
  - T3 `alu_out_en`=1, `reg_in_en`=0x02, `done`=1.
  - Without the macro, the same `instr` gives only `done` in T1.
- Opcode 0xF (`instr`=0xF000): T1 only `done`=1, all other outputs 0.
- Assert `rst` during T2 of an ADD: outputs go to 0 immediately with no `done`; after release, the next edge fetches the current `instr`.
